str_cmp_rx: RTL

Streaming string receiver and comparator. Accepts two NUL-terminated ASCII strings (A, then B) over a valid/ready byte channel, buffers A, and compares B against it character by character while B arrives. Reports SV-string-style relational results (A vs B: EQ/LT/GT), both lengths, and an overflow flag. Provides a getc-style indexed readback of A with optional tolower. Sits at the receive end of the string/character datapath, the hardware counterpart of the string operations exercised in simulation.

---
 rtl/str_pkg.sv | 22 ++
 rtl/str_buf.sv | 57 +++++
 rtl/str_cmp_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/str_pkg.sv
// str_pkg: shared types and helpers for the string receive/compare datapath.
//   state_e   : receiver FSM states (load A, load B, result held)
//   NUL       : string terminator code
//   to_lower  : ASCII tolower (A..Z only, every other code unchanged)
package str_pkg;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StDone
  } state_e;

  localparam logic [7:0] NUL = 8'h00;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c + 8'h20;
    end
    return c;
  endfunction

endpackage

// File: rtl/str_buf.sv
// str_buf: character store for string A.
//   clk, rst          : clock, synchronous active-high reset (readback register only)
//   we, waddr, wdata  : single write port
//   cmp_idx, cmp_data : combinational read port used by the streaming compare
//   len_a             : current stored length, bounds the readback
//   rd_idx, rd_lower  : readback index and tolower select
//   rd_data           : registered readback, 8'h00 for indices at or beyond len_a
// Storage is deliberately not reset; len_a going to zero makes old contents unreachable.
module str_buf
  import str_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [LW-1:0] cmp_idx,
  output logic [7:0]    cmp_data,
  input  logic [LW-1:0] len_a,
  input  logic [LW-1:0] rd_idx,
  input  logic          rd_lower,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] rd_raw;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    cmp_data = NUL;
    if (cmp_idx < LW'(MAX_LEN)) begin
      cmp_data = mem_q[cmp_idx[AW-1:0]];
    end
  end

  assign rd_raw = mem_q[rd_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= NUL;
    end else if (rd_idx < len_a) begin
      rd_data <= rd_lower ? to_lower(rd_raw) : rd_raw;
    end else begin
      rd_data <= NUL;
    end
  end

endmodule

// File: rtl/str_cmp_rx.sv
// str_cmp_rx: receives two NUL-terminated strings A then B on one valid/ready byte
// channel, stores A and compares B against it on the fly.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready/in_char  : character input channel (8'h00 terminates a string)
//   fold_case                  : case-insensitive compare, latched on A's first char
//   res_valid/res_ready        : result handshake
//   res_eq/res_lt/res_gt       : A vs B relation, one-hot while res_valid
//   len_a, len_b, overflow     : saturated lengths and overflow flag
//   rd_idx, rd_lower, rd_data  : registered indexed readback of A
module str_cmp_rx
  import str_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  input  logic          fold_case,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_eq,
  output logic          res_lt,
  output logic          res_gt,
  output logic [LW-1:0] len_a,
  output logic [LW-1:0] len_b,
  output logic          overflow,
  input  logic [LW-1:0] rd_idx,
  input  logic          rd_lower,
  output logic [7:0]    rd_data
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_a_q, len_a_d, len_b_q, len_b_d;
  logic          ovf_q, ovf_d;
  logic          dec_q, dec_d, dec_lt_q, dec_lt_d;
  logic          fold_q, fold_d;
  logic          eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic          acc, is_nul, buf_we;
  logic [7:0]    cmp_a, ca, cb;

  str_buf #(
    .MAX_LEN(MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (buf_we),
    .waddr   (len_a_q[AW-1:0]),
    .wdata   (in_char),
    .cmp_idx (len_b_q),
    .cmp_data(cmp_a),
    .len_a   (len_a_q),
    .rd_idx  (rd_idx),
    .rd_lower(rd_lower),
    .rd_data (rd_data)
  );

  // Held low while rst is asserted so no char is taken during the reset cycle.
  assign in_ready = ~rst & (state_q != StDone);
  assign acc      = in_valid & in_ready;
  assign is_nul   = (in_char == NUL);
  assign buf_we   = acc & (state_q == StLoadA) & ~is_nul & (len_a_q < MaxLen);
  assign ca       = fold_q ? to_lower(cmp_a) : cmp_a;
  assign cb       = fold_q ? to_lower(in_char) : in_char;

  always_comb begin
    state_d  = state_q;
    len_a_d  = len_a_q;
    len_b_d  = len_b_q;
    ovf_d    = ovf_q;
    dec_d    = dec_q;
    dec_lt_d = dec_lt_q;
    fold_d   = fold_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    unique case (state_q)
      StLoadA: begin
        if (acc) begin
          if (len_a_q == '0) begin
            fold_d = fold_case;
          end
          if (is_nul) begin
            state_d = StLoadB;
          end else if (len_a_q < MaxLen) begin
            len_a_d = len_a_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StLoadB: begin
        if (acc) begin
          if (is_nul) begin
            state_d = StDone;
            if (dec_q) begin
              lt_d = dec_lt_q;
              gt_d = ~dec_lt_q;
            end else if (len_a_q == len_b_q) begin
              eq_d = 1'b1;
            end else if (len_a_q > len_b_q) begin
              gt_d = 1'b1;
            end else begin
              lt_d = 1'b1;
            end
          end else begin
            // Chars past MAX_LEN take no part in the compare.
            if (!dec_q && (len_b_q < MaxLen)) begin
              if (len_b_q < len_a_q) begin
                if (ca != cb) begin
                  dec_d    = 1'b1;
                  dec_lt_d = (ca < cb);
                end
              end else begin
                // A ran out first: A is a proper prefix of B.
                dec_d    = 1'b1;
                dec_lt_d = 1'b1;
              end
            end
            if (len_b_q < MaxLen) begin
              len_b_d = len_b_q + LW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d  = StLoadA;
          len_a_d  = '0;
          len_b_d  = '0;
          ovf_d    = 1'b0;
          dec_d    = 1'b0;
          dec_lt_d = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoadA;
      len_a_q  <= '0;
      len_b_q  <= '0;
      ovf_q    <= 1'b0;
      dec_q    <= 1'b0;
      dec_lt_q <= 1'b0;
      fold_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_a_q  <= len_a_d;
      len_b_q  <= len_b_d;
      ovf_q    <= ovf_d;
      dec_q    <= dec_d;
      dec_lt_q <= dec_lt_d;
      fold_q   <= fold_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
    end
  end

  assign res_valid = (state_q == StDone);
  assign res_eq    = eq_q;
  assign res_lt    = lt_q;
  assign res_gt    = gt_q;
  assign len_a     = len_a_q;
  assign len_b     = len_b_q;
  assign overflow  = ovf_q;

endmodule
